reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_if.sv | 34 +++
 rtl/reg_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_reg_scoreboard.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / control bundle between decode and the register scoreboard.
interface reg_scoreboard_if;
    logic        issue_valid;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic        src1_used;
    logic        src2_used;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        drain_req;
    logic        issue_accept;
    logic        stall;
    logic [31:0] busy_mask;
    logic [3:0]  inflight;
    logic        drain_done;
    logic        wb_err;

    // Decode / pipeline side: presents instructions and writebacks.
    modport master (
        output issue_valid, issue_wr, issue_rd, src1_used, src2_used, src1, src2,
               wb_valid, wb_addr, flush, drain_req,
        input  issue_accept, stall, busy_mask, inflight, drain_done, wb_err
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_wr, issue_rd, src1_used, src2_used, src1, src2,
               wb_valid, wb_addr, flush, drain_req,
        output issue_accept, stall, busy_mask, inflight, drain_done, wb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: per-register outstanding-write counters, RAW/WAW
// hazard detection for decode, flush, and a drain handshake for quiescing.
module reg_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned MAX_PER_REG  = 3
) (
    input logic             clk,
    input logic             reset,
    reg_scoreboard_if.slave sb
);

    localparam logic [3:0] MAX_INFLIGHT_C = 4'(MAX_INFLIGHT);
    localparam logic [1:0] MAX_PER_REG_C  = 2'(MAX_PER_REG);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q [32];
    logic [1:0]  cnt_d [32];
    logic [3:0]  inflight_q, inflight_d;
    logic [31:0] busy_q, busy_d;
    logic        wb_err_q, wb_err_d;
    // Set when a drain completes while drain_req is still high; blocks
    // re-entry until drain_req has been seen low.
    logic        rearm_block_q, rearm_block_d;

    logic        hazard_s;
    logic        accept_s;
    logic        inc_s;
    logic        dec_s;
    logic        wb_bad_s;
    logic [31:0] up_vec_s;
    logic [31:0] dn_vec_s;
    logic        drain_done_s;
    logic        in_drain_s;

    // Hazard and accept decisions, taken from registered counters only (no writeback bypass).
    always_comb begin
        hazard_s = (sb.src1_used && (cnt_q[sb.src1] != 2'd0))
                 || (sb.src2_used && (cnt_q[sb.src2] != 2'd0))
                 || (sb.issue_wr && (sb.issue_rd != 5'd0) && (cnt_q[sb.issue_rd] == MAX_PER_REG_C))
                 || (sb.issue_wr && (sb.issue_rd != 5'd0) && (inflight_q == MAX_INFLIGHT_C));
        accept_s = sb.issue_valid && !hazard_s && !sb.flush && !reset && !in_drain_s;
        inc_s    = accept_s && sb.issue_wr && (sb.issue_rd != 5'd0);
        dec_s    = sb.wb_valid && (sb.wb_addr != 5'd0) && (cnt_q[sb.wb_addr] != 2'd0);
        wb_bad_s = sb.wb_valid && (sb.wb_addr != 5'd0) && (cnt_q[sb.wb_addr] == 2'd0);
        if (inc_s) begin
            up_vec_s = 32'd1 << sb.issue_rd;
        end else begin
            up_vec_s = 32'd0;
        end
        if (dec_s) begin
            dn_vec_s = 32'd1 << sb.wb_addr;
        end else begin
            dn_vec_s = 32'd0;
        end
    end

    // Next counter, inflight, busy and error values; flush clears everything but wb_err.
    always_comb begin
        cnt_d[0]  = 2'd0;
        busy_d[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            if (sb.flush) begin
                cnt_d[r] = 2'd0;
            end else if (up_vec_s[r] && !dn_vec_s[r]) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dn_vec_s[r] && !up_vec_s[r]) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
            busy_d[r] = (cnt_d[r] != 2'd0);
        end
        if (sb.flush) begin
            inflight_d = 4'd0;
        end else if (inc_s && !dec_s) begin
            inflight_d = inflight_q + 4'd1;
        end else if (dec_s && !inc_s) begin
            inflight_d = inflight_q - 4'd1;
        end else begin
            inflight_d = inflight_q;
        end
        wb_err_d = wb_err_q || wb_bad_s;
    end

    // Counter, inflight, busy mask and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 2'd0;
            end
            inflight_q <= 4'd0;
            busy_q     <= 32'd0;
            wb_err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // FSM state register and drain re-arm flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rearm_block_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rearm_block_q <= rearm_block_d;
        end
    end

    // FSM next state: track occupancy, enter drain on request, leave when empty.
    always_comb begin
        state_d       = state_q;
        rearm_block_d = rearm_block_q && sb.drain_req;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (sb.drain_req && !rearm_block_q) begin
                    state_d = ST_DRAIN;
                end else if (inflight_d != 4'd0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == 4'd0) begin
                    state_d       = ST_IDLE;
                    rearm_block_d = sb.drain_req;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: drain completion pulse and the issue block while draining.
    always_comb begin
        case (state_q)
            ST_DRAIN: begin
                in_drain_s   = 1'b1;
                drain_done_s = (inflight_q == 4'd0) && !reset;
            end
            default: begin
                in_drain_s   = 1'b0;
                drain_done_s = 1'b0;
            end
        endcase
    end

    assign sb.issue_accept = accept_s;
    assign sb.stall        = sb.issue_valid && !accept_s;
    assign sb.busy_mask    = busy_q;
    assign sb.inflight     = inflight_q;
    assign sb.drain_done   = drain_done_s;
    assign sb.wb_err       = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard with a queue of expected registered results.
module tb_reg_scoreboard;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct {
        logic        rs, fl, dr, iv, wr;
        logic [4:0]  rd;
        logic        u1;
        logic [4:0]  s1;
        logic        u2;
        logic [4:0]  s2;
        logic        wv;
        logic [4:0]  wa;
        logic        ea, ed;
        logic [3:0]  ei;
        logic [31:0] eb;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [3:0]  infl;
        logic [31:0] busy;
        logic        err;
        int          row;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(.MAX_INFLIGHT(8), .MAX_PER_REG(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic vec_t mk(input logic rs, fl, dr, iv, wr, input logic [4:0] rd,
                                input logic u1, input logic [4:0] s1, input logic u2, input logic [4:0] s2,
                                input logic wv, input logic [4:0] wa, input logic ea, ed,
                                input logic [3:0] ei, input logic [31:0] eb, input logic ee);
        vec_t v;
        v.rs = rs; v.fl = fl; v.dr = dr; v.iv = iv; v.wr = wr; v.rd = rd;
        v.u1 = u1; v.s1 = s1; v.u2 = u2; v.s2 = s2; v.wv = wv; v.wa = wa;
        v.ea = ea; v.ed = ed; v.ei = ei; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        reset               = 1'b0;
        sb_if.issue_valid   = 1'b0;
        sb_if.issue_wr      = 1'b0;
        sb_if.issue_rd      = 5'd0;
        sb_if.src1_used     = 1'b0;
        sb_if.src1          = 5'd0;
        sb_if.src2_used     = 1'b0;
        sb_if.src2          = 5'd0;
        sb_if.wb_valid      = 1'b0;
        sb_if.wb_addr       = 5'd0;
        sb_if.flush         = 1'b0;
        sb_if.drain_req     = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int row);
        exp_t e;
        reset             = v.rs;
        sb_if.flush       = v.fl;
        sb_if.drain_req   = v.dr;
        sb_if.issue_valid = v.iv;
        sb_if.issue_wr    = v.wr;
        sb_if.issue_rd    = v.rd;
        sb_if.src1_used   = v.u1;
        sb_if.src1        = v.s1;
        sb_if.src2_used   = v.u2;
        sb_if.src2        = v.s2;
        sb_if.wb_valid    = v.wv;
        sb_if.wb_addr     = v.wa;
        e.infl = v.ei; e.busy = v.eb; e.err = v.ee; e.row = row;
        exp_q.push_back(e);
        @(negedge clk);
        chk("issue_accept", row, 32'(sb_if.issue_accept), 32'(v.ea));
        chk("stall", row, 32'(sb_if.stall), 32'(v.iv & ~v.ea));
        chk("drain_done", row, 32'(sb_if.drain_done), 32'(v.ed));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty row %0d: got 0 entries expected 1", row);
        end else begin
            e = exp_q.pop_front();
            chk("inflight", e.row, 32'(sb_if.inflight), 32'(e.infl));
            chk("busy_mask", e.row, sb_if.busy_mask, e.busy);
            chk("wb_err", e.row, 32'(sb_if.wb_err), 32'(e.err));
        end
    endtask

    initial begin
        int pulses;
        int seen;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset, RAW hazard with no writeback bypass.
        vecs.push_back(mk(T,F,F, T,T,5'd5, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd0,32'h0,F));
        vecs.push_back(mk(F,F,F, T,T,5'd5, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd1,32'h20,F));
        vecs.push_back(mk(F,F,F, T,F,5'd0, T,5'd5,F,5'd0, F,5'd0, F,F, 4'd1,32'h20,F));
        vecs.push_back(mk(F,F,F, T,F,5'd0, T,5'd5,F,5'd0, T,5'd5, F,F, 4'd0,32'h0,F));
        vecs.push_back(mk(F,F,F, T,F,5'd0, T,5'd5,F,5'd0, F,5'd0, T,F, 4'd0,32'h0,F));
        // Per-register limit on r7.
        vecs.push_back(mk(F,F,F, T,T,5'd7, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd1,32'h80,F));
        vecs.push_back(mk(F,F,F, T,T,5'd7, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd2,32'h80,F));
        vecs.push_back(mk(F,F,F, T,T,5'd7, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd3,32'h80,F));
        vecs.push_back(mk(F,F,F, T,T,5'd7, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd3,32'h80,F));
        vecs.push_back(mk(F,F,F, T,T,5'd7, F,5'd0,F,5'd0, T,5'd7, F,F, 4'd2,32'h80,F));
        vecs.push_back(mk(F,F,F, T,T,5'd7, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd3,32'h80,F));
        // Flush blocks a presented issue and clears everything.
        vecs.push_back(mk(F,T,F, T,T,5'd9, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd0,32'h0,F));
        // Fill to the total limit.
        for (int r = 1; r <= 8; r++) begin
            vecs.push_back(mk(F,F,F, T,T,5'(r), F,5'd0,F,5'd0, F,5'd0, T,F, 4'(r),32'((1 << (r + 1)) - 2),F));
        end
        vecs.push_back(mk(F,F,F, T,T,5'd10, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd8,32'h1FE,F));
        vecs.push_back(mk(F,F,F, T,F,5'd0, T,5'd11,T,5'd12, F,5'd0, T,F, 4'd8,32'h1FE,F));
        vecs.push_back(mk(F,F,F, T,T,5'd0, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd8,32'h1FE,F));
        vecs.push_back(mk(F,F,F, T,F,5'd0, F,5'd0,T,5'd3, F,5'd0, F,F, 4'd8,32'h1FE,F));
        vecs.push_back(mk(F,F,F, T,F,5'd0, T,5'd0,F,5'd0, F,5'd0, T,F, 4'd8,32'h1FE,F));
        // Same-cycle issue and writeback to r3.
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd1, F,F, 4'd7,32'h1FC,F));
        vecs.push_back(mk(F,F,F, T,T,5'd3, F,5'd0,F,5'd0, T,5'd3, T,F, 4'd7,32'h1FC,F));
        vecs.push_back(mk(F,F,F, T,T,5'd3, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd8,32'h1FC,F));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd3, F,F, 4'd7,32'h1FC,F));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd3, F,F, 4'd6,32'h1F4,F));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd2, F,F, 4'd5,32'h1F0,F));
        // Flush at inflight=5 with issue and writeback present; r0 writes untracked.
        vecs.push_back(mk(F,T,F, T,T,5'd11, F,5'd0,F,5'd0, T,5'd5, F,F, 4'd0,32'h0,F));
        vecs.push_back(mk(F,F,F, T,T,5'd0, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd0,32'h0,F));
        // Drain with four outstanding writes, drain_req held high throughout.
        for (int r = 1; r <= 4; r++) begin
            vecs.push_back(mk(F,F,F, T,T,5'(r), F,5'd0,F,5'd0, F,5'd0, T,F, 4'(r),32'((1 << (r + 1)) - 2),F));
        end
        vecs.push_back(mk(F,F,T, F,F,5'd0, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd4,32'h1E,F));
        vecs.push_back(mk(F,F,T, T,T,5'd5, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd4,32'h1E,F));
        for (int r = 1; r <= 4; r++) begin
            vecs.push_back(mk(F,F,T, F,F,5'd0, F,5'd0,F,5'd0, T,5'(r), F,F, 4'(4 - r),32'h1E & ~32'((1 << (r + 1)) - 2),F));
        end
        vecs.push_back(mk(F,F,T, F,F,5'd0, F,5'd0,F,5'd0, F,5'd0, F,T, 4'd0,32'h0,F));
        vecs.push_back(mk(F,F,T, T,T,5'd5, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd1,32'h20,F));
        vecs.push_back(mk(F,F,T, T,T,5'd6, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd2,32'h60,F));
        // Stray writeback sets the sticky error; drain re-armed after drain_req low.
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd9, F,F, 4'd2,32'h60,T));
        vecs.push_back(mk(F,F,T, F,F,5'd0, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd2,32'h60,T));
        vecs.push_back(mk(F,F,F, T,T,5'd7, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd2,32'h60,T));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd5, F,F, 4'd1,32'h40,T));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd6, F,F, 4'd0,32'h0,T));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, F,5'd0, F,T, 4'd0,32'h0,T));
        vecs.push_back(mk(F,F,F, T,T,5'd1, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd1,32'h2,T));
        // Mid-operation reset, then the orphaned writeback flags an error.
        vecs.push_back(mk(T,F,F, F,F,5'd0, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd0,32'h0,F));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, T,5'd1, F,F, 4'd0,32'h0,T));
        vecs.push_back(mk(F,F,F, T,F,5'd0, T,5'd1,F,5'd0, F,5'd0, T,F, 4'd0,32'h0,T));
        // Drain entered while empty exits on the next cycle.
        vecs.push_back(mk(F,F,T, F,F,5'd0, F,5'd0,F,5'd0, F,5'd0, F,F, 4'd0,32'h0,T));
        vecs.push_back(mk(F,F,F, F,F,5'd0, F,5'd0,F,5'd0, F,5'd0, F,T, 4'd0,32'h0,T));
        vecs.push_back(mk(F,F,F, T,T,5'd2, F,5'd0,F,5'd0, F,5'd0, T,F, 4'd1,32'h4,T));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Hand sequence: drain with drain_req held high pulses drain_done exactly once.
        drive_idle();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_wr    = 1'b1;
        sb_if.issue_rd    = 5'd10;
        @(negedge clk);
        chk("seq_issue_r10", 100, 32'(sb_if.issue_accept), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        sb_if.drain_req = 1'b1;
        sb_if.wb_valid  = 1'b1;
        sb_if.wb_addr   = 5'd2;
        @(posedge clk);
        #1;
        drive_idle();
        sb_if.drain_req = 1'b1;
        sb_if.wb_valid  = 1'b1;
        sb_if.wb_addr   = 5'd10;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sb_if.drain_done) begin
                pulses++;
            end
            @(posedge clk);
            #1;
            drive_idle();
            sb_if.drain_req = 1'b1;
        end
        chk("seq_drain_pulses", 101, 32'(pulses), 32'd1);
        chk("seq_inflight_empty", 102, 32'(sb_if.inflight), 32'd0);

        // Drop drain_req for a cycle, re-request, and wait (bounded) for completion.
        drive_idle();
        @(posedge clk);
        #1;
        sb_if.drain_req = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (sb_if.drain_done && (seen == 0)) begin
                seen = 1;
            end
            @(posedge clk);
            #1;
        end
        chk("seq_redrain_done", 103, 32'(seen), 32'd1);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_wr    = 1'b1;
        sb_if.issue_rd    = 5'd4;
        @(negedge clk);
        chk("seq_issue_after_drain", 104, 32'(sb_if.issue_accept), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
